// File: rtl/mul_pkg.sv
// Shared types and constants for the MDU multiplier: op encoding, per-op
// operand signedness and the partial-product sign-correction term.
package mul_pkg;

  typedef enum logic [1:0] {
    MUL    = 2'd0,
    MULH   = 2'd1,
    MULHSU = 2'd2,
    MULHU  = 2'd3
  } mul_op_t;

  // Indexed by op encoding: bit set when that operand is treated as signed.
  localparam logic [3:0] ASigned = 4'b0110;
  localparam logic [3:0] BSigned = 4'b0010;

  localparam int unsigned MAX_PW = 128;

  // Negative terms are generated as one's complements; each one needs a +1
  // to become a true two's-complement negation modulo 2^(2*xlen).
  function automatic logic [MAX_PW-1:0] sign_corr(input int unsigned xlen,
                                                 input logic neg_a,
                                                 input logic neg_b,
                                                 input logic neg_m);
    logic [MAX_PW-1:0] c;
    logic [MAX_PW-1:0] mask;
    c    = MAX_PW'(neg_a) + MAX_PW'(neg_b) + MAX_PW'(neg_m);
    mask = '1;
    mask = mask >> (MAX_PW - 2 * xlen);
    return c & mask;
  endfunction

endpackage

// File: rtl/mul_ppgen.sv
// Combinational partial-product generator: splits each operand into MSB and
// low XLEN-1 bits and forms four 2*XLEN terms whose sum is the full product.
module mul_ppgen
  import mul_pkg::*;
#(
  parameter int unsigned XLEN = 64
) (
  input  logic [XLEN-1:0]   SrcA,
  input  logic [XLEN-1:0]   SrcB,
  input  logic [1:0]        Op,
  input  logic              WordOp,
  output logic [2*XLEN-1:0] PP1,
  output logic [2*XLEN-1:0] PP2,
  output logic [2*XLEN-1:0] PP3,
  output logic [2*XLEN-1:0] PP4
);

  localparam int unsigned PW = 2 * XLEN;

  logic [XLEN-1:0]   a, b;
  logic              sa, sb;
  logic [PW-1:0]     a_lo, b_lo, t2, t3, tm;
  logic [MAX_PW-1:0] corr;

  always_comb begin
    a = SrcA;
    b = SrcB;
    if (WordOp) begin
      a        = '0;
      b        = '0;
      a[31:0]  = SrcA[31:0];
      b[31:0]  = SrcB[31:0];
    end
    sa   = ASigned[Op] & ~WordOp;
    sb   = BSigned[Op] & ~WordOp;
    a_lo = PW'(a[XLEN-2:0]);
    b_lo = PW'(b[XLEN-2:0]);
    t2   = a[XLEN-1] ? (b_lo << (XLEN - 1)) : '0;
    t3   = b[XLEN-1] ? (a_lo << (XLEN - 1)) : '0;
    tm   = (a[XLEN-1] & b[XLEN-1]) ? (PW'(1) << (PW - 2)) : '0;
    corr = sign_corr(XLEN, sa, sb, sa ^ sb);
    PP1  = a_lo * b_lo;
    PP2  = sa ? ~t2 : t2;
    PP3  = sb ? ~t3 : t3;
    // MSB x MSB weight is negative exactly when one operand is signed.
    PP4  = ((sa ^ sb) ? ~tm : tm) + corr[PW-1:0];
  end

endmodule

// File: rtl/mul_pipe.sv
// Handshaked, flushable multiplier pipeline (2 or 3 register stages) that
// returns the XLEN-bit result selected by the RISC-V M-extension op.
module mul_pipe
  import mul_pkg::*;
#(
  parameter int unsigned XLEN   = 64,
  parameter int unsigned STAGES = 2,
  parameter int unsigned TAGW   = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            FlushI,
  input  logic            InValid,
  output logic            InReady,
  input  logic [XLEN-1:0] SrcA,
  input  logic [XLEN-1:0] SrcB,
  input  logic [1:0]      Op,
  input  logic            WordOp,
  input  logic [TAGW-1:0] TagI,
  output logic            OutValid,
  input  logic            OutReady,
  output logic [XLEN-1:0] Result,
  output logic [TAGW-1:0] TagO
);

  localparam int unsigned PW = 2 * XLEN;

  function automatic logic [XLEN-1:0] sel(input logic [PW-1:0] prod,
                                          input logic [1:0] op,
                                          input logic word);
    logic [XLEN-1:0] r;
    if (word) begin
      r       = {XLEN{prod[31]}};
      r[31:0] = prod[31:0];
    end else if (mul_op_t'(op) == MUL) begin
      r = prod[XLEN-1:0];
    end else begin
      r = prod[PW-1:XLEN];
    end
    return r;
  endfunction

  logic [PW-1:0]   pp1, pp2, pp3, pp4;
  logic [PW-1:0]   pp1_q, pp2_q, pp3_q, pp4_q;
  logic [1:0]      op1;
  logic            w1;
  logic [TAGW-1:0] tag1;
  logic            v1, v2, adv1, adv2;

  mul_ppgen #(.XLEN(XLEN)) u_ppgen (
    .SrcA   (SrcA),
    .SrcB   (SrcB),
    .Op     (Op),
    .WordOp (WordOp),
    .PP1    (pp1),
    .PP2    (pp2),
    .PP3    (pp3),
    .PP4    (pp4)
  );

  assign adv1    = ~v1 | adv2;
  assign InReady = adv1 & ~FlushI;

  // Data only loads with a valid upstream op, so idle stages keep their contents.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v1    <= 1'b0;
      pp1_q <= '0;
      pp2_q <= '0;
      pp3_q <= '0;
      pp4_q <= '0;
      op1   <= '0;
      w1    <= 1'b0;
      tag1  <= '0;
    end else if (FlushI) begin
      v1 <= 1'b0;
    end else if (adv1) begin
      v1 <= InValid;
      if (InValid) begin
        pp1_q <= pp1;
        pp2_q <= pp2;
        pp3_q <= pp3;
        pp4_q <= pp4;
        op1   <= Op;
        w1    <= WordOp;
        tag1  <= TagI;
      end
    end
  end

  if (STAGES == 3) begin : g_s3
    logic            v3, adv3;
    logic [PW-1:0]   s1_q, s2_q;
    logic [1:0]      op2;
    logic            w2;
    logic [TAGW-1:0] tag2, tag3;
    logic [XLEN-1:0] res3;

    assign adv3 = ~v3 | OutReady;
    assign adv2 = ~v2 | adv3;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        v2   <= 1'b0;
        v3   <= 1'b0;
        s1_q <= '0;
        s2_q <= '0;
        op2  <= '0;
        w2   <= 1'b0;
        tag2 <= '0;
        tag3 <= '0;
        res3 <= '0;
      end else if (FlushI) begin
        v2 <= 1'b0;
        v3 <= 1'b0;
      end else begin
        if (adv2) begin
          v2 <= v1;
          if (v1) begin
            s1_q <= pp1_q + pp2_q;
            s2_q <= pp3_q + pp4_q;
            op2  <= op1;
            w2   <= w1;
            tag2 <= tag1;
          end
        end
        if (adv3) begin
          v3 <= v2;
          if (v2) begin
            res3 <= sel(s1_q + s2_q, op2, w2);
            tag3 <= tag2;
          end
        end
      end
    end

    assign OutValid = v3;
    assign Result   = res3;
    assign TagO     = tag3;
  end else begin : g_s2
    logic [TAGW-1:0] tag2;
    logic [XLEN-1:0] res2;

    assign adv2 = ~v2 | OutReady;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        v2   <= 1'b0;
        tag2 <= '0;
        res2 <= '0;
      end else if (FlushI) begin
        v2 <= 1'b0;
      end else if (adv2) begin
        v2 <= v1;
        if (v1) begin
          res2 <= sel(pp1_q + pp2_q + pp3_q + pp4_q, op1, w1);
          tag2 <= tag1;
        end
      end
    end

    assign OutValid = v2;
    assign Result   = res2;
    assign TagO     = tag2;
  end

  a_word_legal: assert property (@(posedge clk) disable iff (reset)
    (InValid && InReady && WordOp) |-> (XLEN == 64 && Op == 2'd0));

endmodule

// File: tb/tb_mul_pipe.sv
// Directed bench for mul_pipe: a 64-bit 3-stage instance and a 32-bit
// 2-stage instance, covering op selection, latency, backpressure, flush, reset.
module tb_mul_pipe;
  import mul_pkg::*;

  localparam int unsigned ST  = 3;
  localparam int unsigned STN = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        flush, iv, ir, wop, ov, ordy;
  logic [63:0] a, b, res;
  logic [1:0]  op;
  logic [4:0]  tagi, tago;

  logic        flush_n, iv_n, ir_n, wop_n, ov_n, ordy_n;
  logic [31:0] a_n, b_n, res_n;
  logic [1:0]  op_n;
  logic [4:0]  tagi_n, tago_n;

  mul_pipe #(.XLEN(64), .STAGES(ST), .TAGW(5)) u_dut64 (
    .clk(clk), .reset(reset), .FlushI(flush), .InValid(iv), .InReady(ir),
    .SrcA(a), .SrcB(b), .Op(op), .WordOp(wop), .TagI(tagi),
    .OutValid(ov), .OutReady(ordy), .Result(res), .TagO(tago)
  );

  mul_pipe #(.XLEN(32), .STAGES(STN), .TAGW(5)) u_dut32 (
    .clk(clk), .reset(reset), .FlushI(flush_n), .InValid(iv_n), .InReady(ir_n),
    .SrcA(a_n), .SrcB(b_n), .Op(op_n), .WordOp(wop_n), .TagI(tagi_n),
    .OutValid(ov_n), .OutReady(ordy_n), .Result(res_n), .TagO(tago_n)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    iv   = 1'b0;
    iv_n = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic op64(input logic [1:0] o, input logic wd, input logic [63:0] x,
                      input logic [63:0] y, input logic [63:0] exp,
                      input logic [4:0] t, input string nm);
    int lat;
    a = x; b = y; op = o; wop = wd; tagi = t; iv = 1'b1;
    #1;
    check({nm, "_rdy"}, 64'(ir), 64'd1);
    @(posedge clk);
    #1;
    iv  = 1'b0;
    lat = 1;
    while (!ov && lat < 10) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check({nm, "_lat"}, 64'(lat), 64'(ST));
    check(nm, res, exp);
    check({nm, "_tag"}, 64'(tago), 64'(t));
  endtask

  task automatic op32(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                      input logic [31:0] exp, input logic [4:0] t, input string nm);
    int lat;
    a_n = x; b_n = y; op_n = o; tagi_n = t; iv_n = 1'b1;
    #1;
    check({nm, "_rdy"}, 64'(ir_n), 64'd1);
    @(posedge clk);
    #1;
    iv_n = 1'b0;
    lat  = 1;
    while (!ov_n && lat < 10) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check({nm, "_lat"}, 64'(lat), 64'(STN));
    check(nm, 64'(res_n), 64'(exp));
    check({nm, "_tag"}, 64'(tago_n), 64'(t));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int          sent, recvd, cyc, got;
    logic        saw_full, stalled_prev, acc;
    logic [63:0] hold_res;
    logic [4:0]  hold_tag;

    reset = 1'b1;
    flush = 1'b0; iv = 1'b0; ordy = 1'b1; a = '0; b = '0; op = '0; wop = 1'b0; tagi = '0;
    flush_n = 1'b0; iv_n = 1'b0; ordy_n = 1'b1; a_n = '0; b_n = '0; op_n = '0;
    wop_n = 1'b0; tagi_n = '0;
    #12;
    check("rst_ov", 64'(ov), 64'd0);
    check("rst_res", res, 64'd0);
    check("rst_tag", 64'(tago), 64'd0);
    check("rst_rdy", 64'(ir), 64'd1);
    check("rst_ov32", 64'(ov_n), 64'd0);
    check("rst_rdy32", 64'(ir_n), 64'd1);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("post_rst_res", res, 64'd0);

    op64(MUL,    1'b0, '1, '1, 64'h1,                     5'd1, "mul_ones");
    op64(MULH,   1'b0, '1, '1, 64'h0,                     5'd2, "mulh_ones");
    op64(MULHSU, 1'b0, '1, '1, 64'hFFFF_FFFF_FFFF_FFFF,   5'd3, "mulhsu_ones");
    op64(MULHU,  1'b0, '1, '1, 64'hFFFF_FFFF_FFFF_FFFE,   5'd4, "mulhu_ones");
    op64(MUL,    1'b1, 64'h1234_5678_0001_0000, 64'h8000,
         64'hFFFF_FFFF_8000_0000, 5'd5, "mulw");
    op64(MULH,   1'b0, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD,
         64'hFFFF_FFFF_FFFF_FFFF, 5'd6, "mulh_neg");

    op32(MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 5'd7, "mulh32");
    op32(MULHSU, 32'h8000_0000, 32'h8000_0000, 32'hC000_0000, 5'd8, "mulhsu32");
    op32(MUL,    32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 5'd9, "mul32");
    op32(MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 5'd10, "mulhu32");

    // Backpressure: six tagged ops, output stalled for cycles 4..7.
    idle(2);
    sent = 0; recvd = 0; cyc = 0;
    saw_full = 1'b0; stalled_prev = 1'b0; hold_res = '0; hold_tag = '0;
    while (recvd < 6 && cyc < 40) begin
      iv   = (sent < 6);
      tagi = 5'(sent);
      a    = 64'(sent + 1);
      b    = 64'(sent + 100);
      op   = MUL;
      wop  = 1'b0;
      ordy = !(cyc >= 4 && cyc < 8);
      #1;
      check("bp_ready", 64'(ir), 64'(((sent - recvd) < 3) || ordy));
      if ((sent - recvd) == 3 && !ir) saw_full = 1'b1;
      if (ov && stalled_prev) begin
        check("bp_hold_res", res, hold_res);
        check("bp_hold_tag", 64'(tago), 64'(hold_tag));
      end
      if (ov && ordy) begin
        check("bp_tag", 64'(tago), 64'(recvd));
        check("bp_res", res, 64'((recvd + 1) * (recvd + 100)));
        recvd++;
      end
      stalled_prev = ov && !ordy;
      hold_res     = res;
      hold_tag     = tago;
      acc          = iv && ir;
      @(posedge clk);
      #1;
      if (acc) sent++;
      cyc++;
    end
    iv   = 1'b0;
    ordy = 1'b1;
    check("bp_count", 64'(recvd), 64'd6);
    check("bp_full_seen", 64'(saw_full), 64'd1);

    // Flush with two ops in flight and a third presented.
    idle(2);
    iv = 1'b1; tagi = 5'd10; a = 64'd3; b = 64'd4; op = MUL;
    @(posedge clk);
    #1;
    tagi = 5'd11;
    @(posedge clk);
    #1;
    flush = 1'b1;
    tagi  = 5'd12;
    #1;
    check("flush_ready", 64'(ir), 64'd0);
    @(posedge clk);
    #1;
    flush = 1'b0;
    iv    = 1'b0;
    check("flush_ov", 64'(ov), 64'd0);
    got = 0;
    repeat (ST + 2) begin
      @(posedge clk);
      #1;
      if (ov) got++;
    end
    check("flush_none", 64'(got), 64'd0);
    op64(MUL, 1'b0, 64'd6, 64'd7, 64'd42, 5'd13, "post_flush");

    // Asynchronous reset mid-stream with a result held at the output.
    idle(2);
    ordy = 1'b0;
    iv = 1'b1; tagi = 5'd7; a = 64'd5; b = 64'd7; op = MUL;
    @(posedge clk);
    #1;
    tagi = 5'd8; a = 64'd6;
    @(posedge clk);
    #1;
    iv  = 1'b0;
    got = 0;
    while (!ov && got < 10) begin
      @(posedge clk);
      #1;
      got++;
    end
    check("pre_rst_ov", 64'(ov), 64'd1);
    check("pre_rst_res", res, 64'd35);
    #2;
    reset = 1'b1;
    #1;
    check("arst_ov", 64'(ov), 64'd0);
    check("arst_res", res, 64'd0);
    check("arst_tag", 64'(tago), 64'd0);
    check("arst_rdy", 64'(ir), 64'd1);
    @(negedge clk);
    reset = 1'b0;
    ordy  = 1'b1;
    @(posedge clk);
    #1;
    check("arst_after_ov", 64'(ov), 64'd0);
    op64(MULHU, 1'b0, 64'h8000_0000_0000_0000, 64'd4, 64'd2, 5'd20, "post_arst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
